us_seq_ctrl: RTL and testbench

US_SEQ_CTRL -- requirements
Module: us_seq_ctrl

---
 rtl/us_seq_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_us_seq_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/us_seq_ctrl.sv
// Ultrasound sequencer: ramps a DAC level toward a commanded target, then runs a
// transmit burst and/or a receive listening window, with an overriding off command.
module us_seq_ctrl #(
    parameter int AMOUNT_WIDTH  = 8,
    parameter int BURST_CYCLES  = 16,
    parameter int LISTEN_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    input  logic                    on,
    input  logic                    off,
    input  logic                    increase,
    input  logic                    decrease,
    input  logic                    send,
    input  logic                    receive,
    input  logic [AMOUNT_WIDTH-1:0] amount,
    output logic [AMOUNT_WIDTH-1:0] dac_level,
    output logic                    dac_wr,
    output logic                    tx_en,
    output logic                    rx_en,
    output logic                    busy,
    output logic                    cmd_drop
);

    localparam int CNT_MAX = (BURST_CYCLES > LISTEN_CYCLES) ? BURST_CYCLES : LISTEN_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0]        BURST_END  = CNT_W'(BURST_CYCLES - 1);
    localparam logic [CNT_W-1:0]        LISTEN_END = CNT_W'(LISTEN_CYCLES - 1);
    localparam logic [CNT_W-1:0]        CNT_ONE    = CNT_W'(1'b1);
    localparam logic [AMOUNT_WIDTH-1:0] AMT_ONE    = AMOUNT_WIDTH'(1'b1);
    localparam logic [AMOUNT_WIDTH-1:0] AMT_ZERO   = {AMOUNT_WIDTH{1'b0}};

    typedef enum logic [2:0] {
        ST_OFF  = 3'd0,
        ST_IDLE = 3'd1,
        ST_RAMP = 3'd2,
        ST_TX   = 3'd3,
        ST_RX   = 3'd4
    } state_t;

    function automatic logic [AMOUNT_WIDTH-1:0] sat_add(input logic [AMOUNT_WIDTH-1:0] a,
                                                        input logic [AMOUNT_WIDTH-1:0] b);
        logic [AMOUNT_WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[AMOUNT_WIDTH] ? {AMOUNT_WIDTH{1'b1}} : sum[AMOUNT_WIDTH-1:0];
    endfunction

    function automatic logic [AMOUNT_WIDTH-1:0] sat_sub(input logic [AMOUNT_WIDTH-1:0] a,
                                                        input logic [AMOUNT_WIDTH-1:0] b);
        return (a < b) ? AMT_ZERO : (a - b);
    endfunction

    state_t                  state_r, state_nxt_s;
    logic [AMOUNT_WIDTH-1:0] target_r, target_nxt_s;
    logic                    tx_pend_r, tx_pend_nxt_s;
    logic                    rx_pend_r, rx_pend_nxt_s;
    logic [CNT_W-1:0]        cnt_r, cnt_nxt_s;
    logic [AMOUNT_WIDTH-1:0] dac_nxt_s;
    logic                    dac_wr_nxt_s;
    logic                    drop_nxt_s;
    logic                    useful_s;

    // A command in IDLE/RAMP is only acted on if it adjusts the target or queues a burst/window.
    assign useful_s = (increase ^ decrease) | send | receive;

    // Next-state, target, pending flags, counter and DAC step decisions.
    always_comb begin
        state_nxt_s   = state_r;
        target_nxt_s  = target_r;
        tx_pend_nxt_s = tx_pend_r;
        rx_pend_nxt_s = rx_pend_r;
        cnt_nxt_s     = cnt_r;
        dac_nxt_s     = dac_level;
        dac_wr_nxt_s  = 1'b0;
        drop_nxt_s    = 1'b0;
        if (cmd_valid && off) begin
            state_nxt_s   = ST_OFF;
            target_nxt_s  = AMT_ZERO;
            tx_pend_nxt_s = 1'b0;
            rx_pend_nxt_s = 1'b0;
            cnt_nxt_s     = {CNT_W{1'b0}};
            dac_nxt_s     = AMT_ZERO;
            dac_wr_nxt_s  = (dac_level != AMT_ZERO);
        end else begin
            case (state_r)
                ST_OFF: begin
                    if (cmd_valid && on) begin
                        target_nxt_s = amount;
                        state_nxt_s  = (amount == dac_level) ? ST_IDLE : ST_RAMP;
                    end else begin
                        drop_nxt_s = cmd_valid;
                    end
                end
                ST_IDLE, ST_RAMP: begin
                    if (cmd_valid && increase && !decrease) begin
                        target_nxt_s = sat_add(target_r, amount);
                    end else if (cmd_valid && decrease && !increase) begin
                        target_nxt_s = sat_sub(target_r, amount);
                    end else begin
                        target_nxt_s = target_r;
                    end
                    drop_nxt_s    = cmd_valid & ((increase & decrease) | ~useful_s);
                    tx_pend_nxt_s = tx_pend_r | (cmd_valid & send);
                    rx_pend_nxt_s = rx_pend_r | (cmd_valid & receive);
                    // Keep stepping until the level meets the target it was heading to.
                    if ((state_r == ST_RAMP) && (dac_level != target_r)) begin
                        dac_nxt_s    = (dac_level < target_r) ? (dac_level + AMT_ONE)
                                                              : (dac_level - AMT_ONE);
                        dac_wr_nxt_s = 1'b1;
                    end else if (target_nxt_s != dac_level) begin
                        state_nxt_s = ST_RAMP;
                    end else if (tx_pend_nxt_s) begin
                        state_nxt_s   = ST_TX;
                        tx_pend_nxt_s = 1'b0;
                        cnt_nxt_s     = {CNT_W{1'b0}};
                    end else if (rx_pend_nxt_s) begin
                        state_nxt_s   = ST_RX;
                        rx_pend_nxt_s = 1'b0;
                        cnt_nxt_s     = {CNT_W{1'b0}};
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_TX: begin
                    drop_nxt_s = cmd_valid;
                    if (cnt_r == BURST_END) begin
                        cnt_nxt_s = {CNT_W{1'b0}};
                        if (rx_pend_r) begin
                            state_nxt_s   = ST_RX;
                            rx_pend_nxt_s = 1'b0;
                        end else begin
                            state_nxt_s = ST_IDLE;
                        end
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end
                ST_RX: begin
                    drop_nxt_s = cmd_valid;
                    if (cnt_r == LISTEN_END) begin
                        cnt_nxt_s   = {CNT_W{1'b0}};
                        state_nxt_s = ST_IDLE;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt_s = ST_OFF;
                end
            endcase
        end
    end

    // State, internal registers and registered outputs; enables follow the next state
    // so tx_en/rx_en are high in exactly the cycles spent in TX/RX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_OFF;
            target_r  <= AMT_ZERO;
            tx_pend_r <= 1'b0;
            rx_pend_r <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
            dac_level <= AMT_ZERO;
            dac_wr    <= 1'b0;
            tx_en     <= 1'b0;
            rx_en     <= 1'b0;
            busy      <= 1'b0;
            cmd_drop  <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            target_r  <= target_nxt_s;
            tx_pend_r <= tx_pend_nxt_s;
            rx_pend_r <= rx_pend_nxt_s;
            cnt_r     <= cnt_nxt_s;
            dac_level <= dac_nxt_s;
            dac_wr    <= dac_wr_nxt_s;
            tx_en     <= (state_nxt_s == ST_TX);
            rx_en     <= (state_nxt_s == ST_RX);
            busy      <= (state_nxt_s == ST_RAMP) || (state_nxt_s == ST_TX) ||
                         (state_nxt_s == ST_RX);
            cmd_drop  <= drop_nxt_s;
        end
    end

endmodule

// File: tb/tb_us_seq_ctrl.sv
// Directed self-checking bench for us_seq_ctrl with default parameters
// (8-bit amounts, 16-cycle burst, 1024-cycle listen window).
module tb_us_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, on, off, increase, decrease, send, receive;
    logic [7:0] amount;
    logic [7:0] dac_level;
    logic       dac_wr, tx_en, rx_en, busy, cmd_drop;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int cyc_r = 0;
    int tx_cnt_r, rx_cnt_r, ovl_r, last_tx_r, first_rx_r, tx_start_dac_r;

    us_seq_ctrl #(.AMOUNT_WIDTH(8), .BURST_CYCLES(16), .LISTEN_CYCLES(1024)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .on(on), .off(off),
        .increase(increase), .decrease(decrease), .send(send), .receive(receive),
        .amount(amount), .dac_level(dac_level), .dac_wr(dac_wr), .tx_en(tx_en),
        .rx_en(rx_en), .busy(busy), .cmd_drop(cmd_drop)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running, required to finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        cmp_cnt++;
        if (obs !== exp_v) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic clr_acc();
        tx_cnt_r = 0; rx_cnt_r = 0; ovl_r = 0;
        last_tx_r = -1; first_rx_r = -1; tx_start_dac_r = -1;
    endtask

    // One clock; sample at the falling edge and accumulate enable statistics.
    task automatic tick();
        @(negedge clk);
        cyc_r++;
        if (tx_en && rx_en) ovl_r++;
        if (tx_en) begin
            if (tx_cnt_r == 0) tx_start_dac_r = dac_level;
            tx_cnt_r++;
            last_tx_r = cyc_r;
        end
        if (rx_en) begin
            if (first_rx_r < 0) first_rx_r = cyc_r;
            rx_cnt_r++;
        end
    endtask

    task automatic do_cmd(input logic c_on, input logic c_off, input logic c_inc,
                          input logic c_dec, input logic c_send, input logic c_recv,
                          input logic [7:0] c_amt);
        cmd_valid = 1'b1; on = c_on; off = c_off; increase = c_inc; decrease = c_dec;
        send = c_send; receive = c_recv; amount = c_amt;
        tick();
        cmd_valid = 1'b0; on = 1'b0; off = 1'b0; increase = 1'b0; decrease = 1'b0;
        send = 1'b0; receive = 1'b0; amount = 8'd0;
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        int n;
        n = 0;
        while (busy && (n < max_cyc)) begin
            tick();
            n++;
        end
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0; on = 1'b0; off = 1'b0; increase = 1'b0; decrease = 1'b0;
        send = 1'b0; receive = 1'b0; amount = 8'd0;
        clr_acc();
        repeat (3) tick();
        chk("rst_dac",  {24'd0, dac_level}, 32'd0);
        chk("rst_wr",   {31'd0, dac_wr},   32'd0);
        chk("rst_en",   {30'd0, tx_en, rx_en}, 32'd0);
        chk("rst_busy", {30'd0, busy, cmd_drop}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Power on to 5: one step per cycle with a write strobe each step.
        do_cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5);
        chk("on_busy", {31'd0, busy}, 32'd1);
        chk("on_dac0", {24'd0, dac_level}, 32'd0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk($sformatf("ramp_dac%0d", i), {24'd0, dac_level}, i);
            chk($sformatf("ramp_wr%0d", i),  {31'd0, dac_wr}, 32'd1);
        end
        tick();
        chk("ramp_end_wr",   {31'd0, dac_wr}, 32'd0);
        chk("ramp_end_busy", {31'd0, busy}, 32'd0);
        chk("ramp_end_dac",  {24'd0, dac_level}, 32'd5);

        // Conflicting increase+decrease is dropped and leaves the level alone.
        do_cmd(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3);
        chk("incdec_drop", {31'd0, cmd_drop}, 32'd1);
        tick();
        chk("incdec_drop_clr", {31'd0, cmd_drop}, 32'd0);
        chk("incdec_busy", {31'd0, busy}, 32'd0);
        chk("incdec_dac",  {24'd0, dac_level}, 32'd5);

        // Up to 250, then +10 saturates at 255 without wrapping.
        do_cmd(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd245);
        wait_idle("up250", 300);
        chk("up250_dac", {24'd0, dac_level}, 32'd250);
        do_cmd(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd10);
        wait_idle("sat", 50);
        chk("sat_dac", {24'd0, dac_level}, 32'd255);
        repeat (3) tick();
        chk("sat_hold_dac",  {24'd0, dac_level}, 32'd255);
        chk("sat_hold_busy", {31'd0, busy}, 32'd0);

        // Ramp down toward 5 with a send queued mid-ramp: burst starts only at level 5.
        clr_acc();
        do_cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd250);
        tick(); tick();
        do_cmd(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        chk("rampsend_notx", {31'd0, tx_en}, 32'd0);
        wait_idle("rampsend", 400);
        chk("rampsend_start_dac", tx_start_dac_r, 32'd5);
        chk("rampsend_tx_cnt", tx_cnt_r, 32'd16);
        chk("rampsend_rx_cnt", rx_cnt_r, 32'd0);

        // send+receive from IDLE: 16 TX cycles, then 1024 RX cycles, never overlapping.
        clr_acc();
        do_cmd(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0);
        wait_idle("txrx", 1200);
        chk("txrx_tx_cnt", tx_cnt_r, 32'd16);
        chk("txrx_rx_cnt", rx_cnt_r, 32'd1024);
        chk("txrx_overlap", ovl_r, 32'd0);
        chk("txrx_order", first_rx_r, last_tx_r + 1);
        chk("txrx_dac", {24'd0, dac_level}, 32'd5);

        // increase during TX is dropped; burst completes and target is unchanged.
        clr_acc();
        do_cmd(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        repeat (3) tick();
        do_cmd(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd7);
        chk("txinc_drop", {31'd0, cmd_drop}, 32'd1);
        tick();
        chk("txinc_drop_clr", {31'd0, cmd_drop}, 32'd0);
        wait_idle("txinc", 100);
        chk("txinc_tx_cnt", tx_cnt_r, 32'd16);
        repeat (3) tick();
        chk("txinc_busy", {31'd0, busy}, 32'd0);
        chk("txinc_dac",  {24'd0, dac_level}, 32'd5);

        // off during TX: enable drops, DAC zeroed with a write, back in OFF.
        do_cmd(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        tick(); tick();
        chk("txoff_pre_tx", {31'd0, tx_en}, 32'd1);
        do_cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        chk("txoff_tx",   {31'd0, tx_en}, 32'd0);
        chk("txoff_dac",  {24'd0, dac_level}, 32'd0);
        chk("txoff_wr",   {31'd0, dac_wr}, 32'd1);
        chk("txoff_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("txoff_wr_clr", {31'd0, dac_wr}, 32'd0);
        do_cmd(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd4);
        chk("off_inc_drop", {31'd0, cmd_drop}, 32'd1);
        chk("off_inc_busy", {31'd0, busy}, 32'd0);

        // Reset mid-ramp: everything cleared and stays in OFF afterwards.
        do_cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd100);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("rstmid_dac",  {24'd0, dac_level}, 32'd0);
        chk("rstmid_flags", {27'd0, dac_wr, tx_en, rx_en, busy, cmd_drop}, 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("rstmid_after_dac",  {24'd0, dac_level}, 32'd0);
        chk("rstmid_after_flags", {27'd0, dac_wr, tx_en, rx_en, busy, cmd_drop}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
